// File: rtl/count_sched_pkg.sv
// Shared definitions for the two-requester burst scheduler: FSM encoding,
// default burst-length width and the arbiter's pointer reset value.
package count_sched_pkg;

  localparam int LEN_W_DEF = 4;

  // Last-grant pointer starts at requester 1 so requester 0 wins the first tie.
  localparam logic LAST_GNT_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage : count_sched_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant
// pointer updated only when the grant is actually taken.
module rr_arb2
  import count_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_q, last_d;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (take && gnt_valid) begin
      last_d = gnt_id;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset here is synchronous and takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= LAST_GNT_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/count_sched.sv
// Burst scheduler: accepts a length from one of two requesters, issues that
// many enable strobes to the selected counter channel, then pulses Done.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0_valid,
  input  logic [LEN_W-1:0] Req0_len,
  output logic             Req0_ready,
  input  logic             Req1_valid,
  input  logic [LEN_W-1:0] Req1_len,
  output logic             Req1_ready,
  input  logic             Hold,
  output logic             Cnt_en,
  output logic             Cnt_slt,
  output logic             Busy,
  output logic             Done,
  output logic             Done_id
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             id_q, id_d;

  logic             gnt_valid;
  logic             gnt_id;
  logic             can_accept;
  logic             accept;
  logic [LEN_W-1:0] sel_len;

  rr_arb2 u_arb (
    .clk      (Clk),
    .reset    (Reset),
    .req      ({Req1_valid, Req0_valid}),
    .take     (accept),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // Nothing is accepted in a reset cycle, so the handshake is masked too.
  assign can_accept = (state_q == IDLE) && !Reset;
  assign accept     = can_accept && gnt_valid;
  assign Req0_ready = accept && !gnt_id;
  assign Req1_ready = accept && gnt_id;
  assign sel_len    = gnt_id ? Req1_len : Req0_len;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    id_d        = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d = gnt_id;
          if (sel_len == '0) begin
            state_d = FINISH;
          end else begin
            remaining_d = sel_len;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!Hold) begin
          // Saturating decrement: the counter never wraps below zero.
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          if (remaining_q <= LEN_W'(1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      id_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      id_q        <= id_d;
    end
  end

  // Outputs are decoded from the state register; Hold gates the strobe in the
  // same cycle and Reset forces everything quiet while it is asserted.
  always_comb begin
    Cnt_en  = 1'b0;
    Cnt_slt = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    Done_id = 1'b0;
    if (!Reset) begin
      Busy = (state_q != IDLE);
      case (state_q)
        ISSUE: begin
          Cnt_en  = !Hold;
          Cnt_slt = !Hold && id_q;
        end
        FINISH: begin
          Done    = 1'b1;
          Done_id = id_q;
        end
        default: begin
          Cnt_en = 1'b0;
        end
      endcase
    end
  end

  a_one_ready : assert property (@(posedge Clk) !(Req0_ready && Req1_ready));
  a_slt_en    : assert property (@(posedge Clk) Cnt_slt |-> Cnt_en);
  a_legal_st  : assert property (@(posedge Clk) disable iff (Reset)
                                 state_q inside {IDLE, ISSUE, FINISH});

endmodule : count_sched

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: table of bursts with a per-cycle
// expectation queue, plus a hand-written reset-abort sequence.
module tb_count_sched;

  localparam int LW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Req0_valid, Req1_valid;
  logic [LW-1:0] Req0_len, Req1_len;
  logic          Req0_ready, Req1_ready;
  logic          Hold;
  logic          Cnt_en, Cnt_slt, Busy, Done, Done_id;

  count_sched #(.LEN_W(LW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req0_valid(Req0_valid),
    .Req0_len  (Req0_len),
    .Req0_ready(Req0_ready),
    .Req1_valid(Req1_valid),
    .Req1_len  (Req1_len),
    .Req1_ready(Req1_ready),
    .Hold      (Hold),
    .Cnt_en    (Cnt_en),
    .Cnt_slt   (Cnt_slt),
    .Busy      (Busy),
    .Done      (Done),
    .Done_id   (Done_id)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          v0;
    logic [LW-1:0] l0;
    logic          v1;
    logic [LW-1:0] l1;
    logic          exp_id;
    int            exp_len;
    int            hold_at;
    int            hold_n;
    logic          chg;
  } vec_t;

  typedef struct {
    logic hold;
    logic en;
    logic slt;
    logic done;
    logic did;
    logic busy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle outputs for one accepted burst, starting the cycle after accept.
  task automatic push_burst(input logic id, input int len, input int hold_at, input int hold_n);
    for (int p = 1; p <= len; p++) begin
      sb.push_back('{hold: 1'b0, en: 1'b1, slt: id, done: 1'b0, did: 1'b0, busy: 1'b1});
      if (p == hold_at) begin
        for (int h = 0; h < hold_n; h++) begin
          sb.push_back('{hold: 1'b1, en: 1'b0, slt: 1'b0, done: 1'b0, did: 1'b0, busy: 1'b1});
        end
      end
    end
    // Hold is driven during FINISH for hold bursts: it must not delay Done.
    sb.push_back('{hold: (hold_n != 0), en: 1'b0, slt: 1'b0, done: 1'b1, did: id, busy: 1'b1});
  endtask

  task automatic drain(input int n);
    exp_t e;
    int   left;
    left = n;
    while (sb.size() > 0 && left != 0) begin
      e = sb.pop_front();
      left--;
      Hold = e.hold;
      @(negedge Clk);
      check("en_slt_done_did_busy", {27'd0, Cnt_en, Cnt_slt, Done, Done_id, Busy},
            {27'd0, e.en, e.slt, e.done, e.did, e.busy});
      @(posedge Clk);
      #1;
    end
    Hold = 1'b0;
  endtask

  task automatic offer(input vec_t v);
    Req0_valid = v.v0;
    Req0_len   = v.l0;
    Req1_valid = v.v1;
    Req1_len   = v.l1;
    @(negedge Clk);
    check("ready1_ready0_busy_en_done", {27'd0, Req1_ready, Req0_ready, Busy, Cnt_en, Done},
          {27'd0, v.exp_id, !v.exp_id, 3'b000});
    @(posedge Clk);
    #1;
    if (v.chg) begin
      if (v.exp_id) Req1_len = LW'(2);
      else          Req0_len = LW'(2);
    end
    push_burst(v.exp_id, v.exp_len, v.hold_at, v.hold_n);
    drain(-1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v0    l0     v1    l1     id    len hat hn chg
    vecs[0] = '{1'b1, 4'd2,  1'b1, 4'd2,  1'b0, 2,  0,  0, 1'b0};
    vecs[1] = '{1'b1, 4'd2,  1'b1, 4'd2,  1'b1, 2,  0,  0, 1'b0};
    vecs[2] = '{1'b1, 4'd2,  1'b1, 4'd2,  1'b0, 2,  0,  0, 1'b0};
    vecs[3] = '{1'b1, 4'd2,  1'b1, 4'd2,  1'b1, 2,  0,  0, 1'b0};
    vecs[4] = '{1'b1, 4'd3,  1'b0, 4'd0,  1'b0, 3,  0,  0, 1'b0};
    vecs[5] = '{1'b0, 4'd0,  1'b1, 4'd4,  1'b1, 4,  2,  2, 1'b0};
    vecs[6] = '{1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 0,  0,  0, 1'b0};
    vecs[7] = '{1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 15, 0,  0, 1'b1};
    vecs[8] = '{1'b1, 4'd1,  1'b1, 4'd5,  1'b1, 5,  0,  0, 1'b0};
    vecs[9] = '{1'b1, 4'd1,  1'b1, 4'd5,  1'b0, 1,  0,  0, 1'b0};

    Reset      = 1'b1;
    Hold       = 1'b0;
    Req0_valid = 1'b1;
    Req0_len   = 4'd3;
    Req1_valid = 1'b0;
    Req1_len   = 4'd0;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("in_reset_quiet", {26'd0, Cnt_en, Cnt_slt, Done, Done_id, Busy, Req0_ready},
          32'd0);
    @(posedge Clk);
    #1;
    Req0_valid = 1'b0;
    Reset      = 1'b0;
    @(negedge Clk);
    check("post_reset_quiet", {25'd0, Cnt_en, Cnt_slt, Done, Done_id, Busy, Req0_ready,
          Req1_ready}, 32'd0);
    @(posedge Clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      offer(vecs[i]);
    end

    // Long burst on requester 1 aborted by reset after the fifth strobe.
    Req0_valid = 1'b0;
    Req0_len   = 4'd0;
    Req1_valid = 1'b1;
    Req1_len   = 4'd15;
    @(negedge Clk);
    check("abort_ready1", {30'd0, Req1_ready, Req0_ready}, 32'b10);
    @(posedge Clk);
    #1;
    push_burst(1'b1, 15, 0, 0);
    drain(5);
    sb.delete();
    Reset      = 1'b1;
    Req0_valid = 1'b1;
    Req0_len   = 4'd2;
    Req1_valid = 1'b1;
    Req1_len   = 4'd1;
    @(negedge Clk);
    check("abort_reset_cycle", {26'd0, Cnt_en, Cnt_slt, Done, Busy, Req0_ready, Req1_ready},
          32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    offer('{1'b1, 4'd2, 1'b1, 4'd1, 1'b0, 2, 0, 0, 1'b0});
    offer('{1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 1, 0, 0, 1'b0});

    Req0_valid = 1'b0;
    Req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("idle_tail", {28'd0, Cnt_en, Done, Busy, Req0_ready | Req1_ready}, 32'd0);
      @(posedge Clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_count_sched
